// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the N-master memory arbiter: FSM encoding,
// priority-mode constants and the index-width helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    localparam int RR_FIXED = 0;
    localparam int RR_ROUND = 1;

    // A single master still needs a one-bit owner register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection: fixed priority (lowest index) or round-robin
// starting just above the last granted master.
module rr_picker
    import mem_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int RR_MODE   = RR_ROUND,
    parameter int IDX_W     = idx_width(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]     last_gnt_i,
    output logic [N_MASTERS-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 valid_o
);

    logic [N_MASTERS-1:0] mask;
    logic [N_MASTERS-1:0] masked_req;
    logic [N_MASTERS-1:0] pick_vec;

    // Round-robin: prefer requesters above last_gnt; if none, wrap to the full set.
    // NOTE: every output of a combinational block gets a default before any branch, otherwise a latch is inferred.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            mask[i] = (RR_MODE == RR_ROUND) && (i > int'(last_gnt_i));
        end
        masked_req = req_i & mask;
        pick_vec   = (|masked_req) ? masked_req : req_i;
        gnt_o      = pick_vec & (~pick_vec + N_MASTERS'(1));
        idx_o      = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (gnt_o[i]) begin
                idx_o = idx_o | IDX_W'(i);
            end
        end
        valid_o = |req_i;
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-master to single-slave memory arbiter with a ready-handshaked slave port,
// per-master completion/error pulses and a slave-timeout watchdog.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int RR_MODE   = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [N_MASTERS-1:0]          req,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS-1:0]          m_write,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    output logic [N_MASTERS-1:0]          done,
    output logic [N_MASTERS-1:0]          err,
    output logic [N_MASTERS-1:0]          stall,
    output logic [DATA_W-1:0]             rdata,
    output logic                          PSEL,
    output logic [ADDR_W-1:0]             PADDR,
    output logic                          PWRITE,
    output logic [DATA_W-1:0]             PWDATA,
    input  logic                          PREADY,
    input  logic [DATA_W-1:0]             PRDATA
);

    localparam int          IDX_W    = idx_width(N_MASTERS);
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_gnt_q, last_gnt_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                err_flag_q, err_flag_d;
    logic                psel_q, psel_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [N_MASTERS-1:0] win_gnt;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_valid;
    logic [ADDR_W-1:0]    sel_addr;
    logic                 sel_write;
    logic [DATA_W-1:0]    sel_wdata;

    rr_picker #(
        .N_MASTERS (N_MASTERS),
        .RR_MODE   (RR_MODE),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req_i      (req),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (win_gnt),
        .idx_o      (win_idx),
        .valid_o    (win_valid)
    );

    // One-hot grant drives an AND-OR mux of the winner's request fields.
    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (win_gnt[i]) begin
                sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
                sel_write = m_write[i];
                sel_wdata = m_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        psel_d     = psel_q;
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    owner_d  = win_idx;
                    paddr_d  = sel_addr;
                    pwrite_d = sel_write;
                    pwdata_d = sel_wdata;
                    psel_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // A slave completing on the last allowed cycle still wins over the watchdog.
                if (PREADY) begin
                    if (!pwrite_q) begin
                        rdata_d = PRDATA;
                    end
                    psel_d  = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    psel_d     = 1'b0;
                    err_flag_d = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                if (RR_MODE == RR_ROUND) begin
                    last_gnt_d = owner_q;
                end
                err_flag_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            last_gnt_q <= IDX_W'(N_MASTERS - 1);
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
            psel_q     <= 1'b0;
            paddr_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            err_flag_q <= err_flag_d;
            psel_q     <= psel_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        done = '0;
        err  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (state_q == S_RESP && owner_q == IDX_W'(i)) begin
                done[i] = 1'b1;
                err[i]  = err_flag_q;
            end
        end
    end

    assign stall  = req & ~done;
    assign rdata  = rdata_q;
    assign PSEL   = psel_q;
    assign PADDR  = paddr_q;
    assign PWRITE = pwrite_q;
    assign PWDATA = pwdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance, directed
// scenarios followed by randomized traffic against a transaction-level model.
module tb_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b0;

    // Index 0: round-robin instance, index 1: fixed-priority instance.
    logic [N-1:0]    req     [2];
    logic [N*AW-1:0] m_addr  [2];
    logic [N-1:0]    m_write [2];
    logic [N*DW-1:0] m_wdata [2];
    logic [N-1:0]    done    [2];
    logic [N-1:0]    err     [2];
    logic [N-1:0]    stall   [2];
    logic [DW-1:0]   rdata   [2];
    logic            psel    [2];
    logic [AW-1:0]   paddr   [2];
    logic            pwrite  [2];
    logic [DW-1:0]   pwdata  [2];
    logic            pready  [2];
    logic [DW-1:0]   prdata  [2];

    int n_pass   = 0;
    int n_checks = 0;
    int n_fail   = 0;

    int            last_m  [2];
    logic [DW-1:0] rdata_m [2];

    always #5 CLK = ~CLK;

    mem_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(TO)) u_rr (
        .CLK(CLK), .RESET(RESET), .req(req[0]), .m_addr(m_addr[0]), .m_write(m_write[0]),
        .m_wdata(m_wdata[0]), .done(done[0]), .err(err[0]), .stall(stall[0]), .rdata(rdata[0]),
        .PSEL(psel[0]), .PADDR(paddr[0]), .PWRITE(pwrite[0]), .PWDATA(pwdata[0]),
        .PREADY(pready[0]), .PRDATA(prdata[0])
    );

    mem_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(TO)) u_fx (
        .CLK(CLK), .RESET(RESET), .req(req[1]), .m_addr(m_addr[1]), .m_write(m_write[1]),
        .m_wdata(m_wdata[1]), .done(done[1]), .err(err[1]), .stall(stall[1]), .rdata(rdata[1]),
        .PSEL(psel[1]), .PADDR(paddr[1]), .PWRITE(pwrite[1]), .PWDATA(pwdata[1]),
        .PREADY(pready[1]), .PRDATA(prdata[1])
    );

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    task automatic check(input int d, input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL dut%0d %s: observed %0h expected %0h", d, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            last_m[d]  = N - 1;
            rdata_m[d] = '0;
        end
    endtask

    // Winner by the arbitration rule: lowest index, or first set index after the last grant.
    function automatic int pick(input int d, input logic [N-1:0] r);
        int idx;
        if (d == 1) begin
            for (int i = 0; i < N; i++) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) begin
                idx = (last_m[d] + k) % N;
                if (r[idx]) return idx;
            end
        end
        return -1;
    endfunction

    task automatic raise(input int d, input int j, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        req[d][j]               = 1'b1;
        m_write[d][j]           = wr;
        m_addr[d][j*AW +: AW]   = a;
        m_wdata[d][j*DW +: DW]  = wd;
    endtask

    task automatic raise_rand(input int d, input int j);
        raise(d, j, 1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    task automatic check_idle_outputs(input int d);
        check(d, "psel", 64'(psel[d]), 64'(0));
        check(d, "done", 64'(done[d]), 64'(0));
        check(d, "err", 64'(err[d]), 64'(0));
        check(d, "rdata", 64'(rdata[d]), 64'(rdata_m[d]));
        check(d, "stall", 64'(stall[d]), 64'(req[d]));
    endtask

    // Runs one access; entered at a negedge with the DUT idle and req pending.
    task automatic run_txn(input int d, input int waits, input logic [DW-1:0] rd, input int keep, input int arrive);
        int            w;
        int            c;
        int            j;
        bit            timed_out;
        logic [AW-1:0] ea;
        logic          ew;
        logic [DW-1:0] ewd;
        logic [N-1:0]  exp_done;
        w = pick(d, req[d]);
        if (w < 0) return;
        ea  = m_addr[d][w*AW +: AW];
        ew  = m_write[d][w];
        ewd = m_wdata[d][w*DW +: DW];
        @(posedge CLK);
        #1;
        m_addr[d][w*AW +: AW]  = $urandom;
        m_wdata[d][w*DW +: DW] = $urandom;
        m_write[d][w]          = ~ew;
        c = 0;
        timed_out = 0;
        while (1) begin
            @(negedge CLK);
            check(d, "psel_access", 64'(psel[d]), 64'(1));
            check(d, "paddr", 64'(paddr[d]), 64'(ea));
            check(d, "pwrite", 64'(pwrite[d]), 64'(ew));
            check(d, "pwdata", 64'(pwdata[d]), 64'(ewd));
            check(d, "done_access", 64'(done[d]), 64'(0));
            check(d, "stall_access", 64'(stall[d]), 64'(req[d]));
            if (arrive == 2 && c == 0) begin
                for (int k = 0; k < N; k++) if (k != w && !req[d][k]) raise_rand(d, k);
            end else if (arrive == 1 && $urandom_range(0, 1) == 1) begin
                j = $urandom_range(0, N - 1);
                if (j != w && !req[d][j]) raise_rand(d, j);
            end
            if (c == waits) begin
                pready[d] = 1'b1;
                prdata[d] = rd;
                break;
            end
            if (c == TO - 1) begin
                timed_out = 1;
                break;
            end
            c++;
        end
        @(posedge CLK);
        #1;
        pready[d] = 1'b0;
        prdata[d] = $urandom;
        if (!timed_out && !ew) rdata_m[d] = rd;
        @(negedge CLK);
        exp_done    = '0;
        exp_done[w] = 1'b1;
        check(d, "done", 64'(done[d]), 64'(exp_done));
        check(d, "err", 64'(err[d]), timed_out ? 64'(exp_done) : 64'(0));
        check(d, "rdata", 64'(rdata[d]), 64'(rdata_m[d]));
        check(d, "psel_resp", 64'(psel[d]), 64'(0));
        check(d, "stall_resp", 64'(stall[d]), 64'(req[d] & ~exp_done));
        if (d == 0) last_m[d] = w;
        if (keep != 0) raise_rand(d, w);
        else req[d][w] = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check(d, "done_after", 64'(done[d]), 64'(0));
        check(d, "psel_after", 64'(psel[d]), 64'(0));
    endtask

    task automatic idle_step(input int d);
        @(posedge CLK);
        @(negedge CLK);
        check_idle_outputs(d);
    endtask

    task automatic drain(input int d);
        while (req[d] != '0) run_txn(d, $urandom_range(0, 2), $urandom, 0, 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; m_addr[d] = '0; m_write[d] = '0; m_wdata[d] = '0;
            pready[d] = 1'b0; prdata[d] = '0;
        end
        model_reset();
        repeat (2) @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            check_idle_outputs(d);
            check(d, "paddr_rst", 64'(paddr[d]), 64'(0));
            check(d, "pwrite_rst", 64'(pwrite[d]), 64'(0));
            check(d, "pwdata_rst", 64'(pwdata[d]), 64'(0));
        end
        RESET = 1'b1;

        // Zero-wait read by master 0, then a 3-wait write by master 1.
        raise(0, 0, 1'b0, 32'h1000, 32'h0);
        run_txn(0, 0, 32'hDEADBEEF, 0, 0);
        raise(0, 1, 1'b1, 32'h2000, 32'h55AA);
        run_txn(0, 3, 32'h12345678, 0, 0);
        check(0, "rdata_kept", 64'(rdata[0]), 64'(32'hDEADBEEF));

        // All masters requesting continuously: rotation vs. fixed priority.
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < N; j++) raise_rand(d, j);
            repeat (6) run_txn(d, 0, $urandom, 1, 0);
            req[d] = '0;
            idle_step(d);
        end

        // Slave stuck low: watchdog abort, then a normal access.
        raise(0, 0, 1'b0, 32'hA0, 32'h0);
        run_txn(0, 10, $urandom, 0, 0);
        raise(0, 2, 1'b0, 32'hB0, 32'h0);
        run_txn(0, 1, 32'hCAFE0001, 0, 0);

        // Contention: others raise req while master 0 owns the port.
        for (int d = 0; d < 2; d++) begin
            raise_rand(d, 0);
            run_txn(d, 2, $urandom, 0, 2);
            drain(d);
        end

        // Reset in the middle of an access.
        for (int j = 0; j < N; j++) raise_rand(0, j);
        @(posedge CLK);
        @(negedge CLK);
        check(0, "psel_pre_reset", 64'(psel[0]), 64'(1));
        #2;
        RESET = 1'b0;
        #1;
        check(0, "psel_async_reset", 64'(psel[0]), 64'(0));
        check(0, "done_async_reset", 64'(done[0]), 64'(0));
        @(posedge CLK);
        @(negedge CLK);
        model_reset();
        check_idle_outputs(0);
        check_idle_outputs(1);
        RESET = 1'b1;
        check(0, "winner_after_reset", 64'(pick(0, req[0])), 64'(0));
        run_txn(0, 0, $urandom, 0, 0);
        drain(0);

        // Randomized traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int it = 0; it < 40; it++) begin
                if (req[d] == '0) begin
                    if ($urandom_range(0, 3) == 0) idle_step(d);
                    for (int j = 0; j < N; j++) if ($urandom_range(0, 1) == 1) raise_rand(d, j);
                    if (req[d] == '0) raise_rand(d, $urandom_range(0, N - 1));
                end
                run_txn(d, $urandom_range(0, 5), $urandom, $urandom_range(0, 1), 1);
            end
            drain(d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-master to 1-slave memory arbiter that replaces the fixed two-port memory controller in the CPU top.
- Masters (instruction fetch, memory access, future DMA/debug) issue single-beat read/write requests.
- The arbiter grants one master at a time, drives a ready-handshaked memory port, returns read data and a completion pulse to the owner, and stalls the others.
- Supports fixed or round-robin priority and a slave-timeout watchdog.

Parameters:
- N_MASTERS, 2, number of requesting masters (2..8)
- ADDR_W, 64, address width
- DATA_W, 64, data width
- RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
- TIMEOUT, 255, max ACCESS cycles waiting for PREADY before error abort (1..65535)

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  reset, asynchronous, active-low
- req  in  N_MASTERS  per-master request, held until done
- m_addr  in  N_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
- m_write  in  N_MASTERS  1 = write
- m_wdata  in  N_MASTERS*DATA_W  packed write data
- done  out  N_MASTERS  one-cycle completion pulse to owner
- err  out  N_MASTERS  one-cycle timeout pulse to owner (coincident with done)
- stall  out  N_MASTERS  req[i] & ~done[i], combinational
- rdata  out  DATA_W  read data, valid when done pulses, held until next completion
- PSEL  out  1  slave access active
- PADDR  out  ADDR_W  registered address
- PWRITE  out  1  registered write flag
- PWDATA  out  DATA_W  registered write data
- PREADY  in  1  slave completes access this cycle
- PRDATA  in  DATA_W  slave read data, sampled when PREADY=1

Behaviour:
- Reset values (asynchronous on RESET low):
  - state=IDLE; PSEL=0; PADDR=0; PWRITE=0; PWDATA=0
  - done=0; err=0; rdata=0; owner=0
  - last_gnt=N_MASTERS-1, so master 0 wins first in RR mode
  - timeout counter=0
- FSM states IDLE, ACCESS, RESP.
- IDLE: if any req=1, select winner w:
  - RR_MODE=0: lowest set index.
  - RR_MODE=1: first set index searching upward from last_gnt+1, wrapping modulo N_MASTERS.
  - On the clock edge: latch owner=w; load PADDR/PWRITE/PWDATA from master w; PSEL<=1; counter<=0; go to ACCESS.
  - No req: stay in IDLE.
- ACCESS: PSEL=1; address, write flag and write data are held stable.
  - PREADY=1: rdata<=PRDATA (reads only; writes leave rdata unchanged); PSEL<=0; go to RESP.
  - PREADY=0 with counter==TIMEOUT-1: PSEL<=0; set error flag; go to RESP; rdata unchanged.
  - Otherwise counter increments.
- RESP: done[owner]=1 and err[owner]=flag, both exactly one cycle.
  - In RR mode last_gnt<=owner (fixed mode ignores last_gnt).
  - Clear flag; go to IDLE.
- Latency: request seen in IDLE at cycle 0 → PSEL high cycles 1..k; PREADY at cycle k → done at cycle k+1. Zero-wait slave gives done 2 cycles after the grant edge.
- A master sees a new grant no earlier than 1 cycle after its done.
- Masters must deassert req, or present a new request, in the cycle after done.
- Request and completion timing:
  - req arriving while the arbiter is busy waits; its stall stays high.
  - Owner dropping req mid-ACCESS does not abort: the access completes and done still pulses.
  - Masters' inputs are sampled only at the grant edge; later changes are ignored.
- Simultaneous requests resolve strictly by the mode rule. In RR mode, with all masters continuously requesting, grants rotate 0,1,...,N-1,0.
- Reset asserted mid-ACCESS: PSEL drops immediately (async), no done/err is issued, and arbitration restarts from the reset state.
- A single-bit err is never asserted without done.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2
  - RR_MODE constants
  - clog2 helper for owner/last_gnt width (max(1,clog2(N_MASTERS)))
- One sub-module, rr_picker: combinational winner selection from req, last_gnt and RR_MODE.
  - Outputs a one-hot grant and an encoded index.
  - Unit-testable on its own.
- The FSM, counter and datapath registers stay in mem_arbiter.

Test Plan:
- Single read, master 0, m_addr=0x1000, slave PREADY on the first ACCESS cycle with PRDATA=0xDEADBEEF → PADDR=0x1000 and PWRITE=0 while PSEL=1 for 1 cycle; done[0] 2 cycles after grant; rdata=0xDEADBEEF.
- Write with 3 wait states, master 1, m_wdata=0x55AA → PSEL high 4 cycles with PWDATA=0x55AA stable; done[1] one pulse; rdata unchanged.
- RR_MODE=1, N=3, all req held high → grant order 0,1,2,0,1,2. RR_MODE=0, same stimulus → master 0 is granted every time.
- Contention: master 0 in ACCESS, master 1 raises req → stall[1]=1 until its own done; stall[0] falls in its done cycle.
- Timeout with TIMEOUT=4 and PREADY stuck low → PSEL high exactly 4 cycles; done[owner]=1 and err[owner]=1 together for 1 cycle; the next request is served normally.
- RESET pulled low during ACCESS → PSEL=0 asynchronously, no done; after release master 0 wins the first arbitration.
